// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter that shares one full-handshake CDC transmitter among NUM_REQ producers.
// Define CDC_ARB_FIXED_PRIO_EN to use fixed priority (lowest index wins) instead of round robin.
module cdc_tx_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          tclock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         xfer_data,
    output logic                          xfer_req,
    input  logic                          xfer_ready,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy,
    output logic [15:0]                   xfer_count
);

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [15:0]           xfer_count_q, xfer_count_d;
`ifndef CDC_ARB_FIXED_PRIO_EN
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic [DATA_WIDTH-1:0] sel_data;

    // Scan upward from the search base and wrap; the first valid requester wins.
    always_comb begin : search
        int                  base;
        int                  idx;
        logic [ID_WIDTH-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
`ifdef CDC_ARB_FIXED_PRIO_EN
        base   = 0;
`else
        base   = int'(rr_ptr_q);
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            idx  = (base + i) % NUM_REQ;
            cand = ID_WIDTH'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin : data_mux
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_WIDTH'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        xfer_data_d  = xfer_data_q;
        grant_id_d   = grant_id_q;
        xfer_count_d = xfer_count_q;
`ifndef CDC_ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_OFFER;
                    xfer_data_d = sel_data;
                    grant_id_d  = winner;
`ifndef CDC_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = ID_WIDTH'((int'(winner) + 1) % NUM_REQ);
`endif
                end
            end
            S_OFFER: begin
                if (xfer_ready) begin
                    state_d      = S_IDLE;
                    xfer_count_d = xfer_count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge tclock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            xfer_data_q  <= '0;
            grant_id_q   <= '0;
            xfer_count_q <= '0;
`ifndef CDC_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            xfer_data_q  <= xfer_data_d;
            grant_id_q   <= grant_id_d;
            xfer_count_q <= xfer_count_d;
`ifndef CDC_ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    // Ready is gated by reset so no requester sees an accept while the block is held in reset.
    always_comb begin : ready_decode
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = reset && (state_q == S_IDLE) && found && (winner == ID_WIDTH'(i));
        end
    end

    assign xfer_req   = (state_q == S_OFFER);
    assign busy       = (state_q == S_OFFER);
    assign xfer_data  = xfer_data_q;
    assign grant_id   = grant_id_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter: grant vector table, scoreboard of offered words,
// and hand-written stall, reset and counter-wrap sequences.
`timescale 1ns/1ps
module tb_cdc_tx_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

`ifdef CDC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             tclock;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    xfer_data;
    logic             xfer_req;
    logic             xfer_ready;
    logic [IW-1:0]    grant_id;
    logic             busy;
    logic [15:0]      xfer_count;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [NR-1:0] valid;
        int            grant;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[10];
    int          order[5];
    int          checks    = 0;
    int          errors    = 0;
    logic [15:0] exp_count = '0;

    cdc_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .tclock     (tclock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .xfer_data  (xfer_data),
        .xfer_req   (xfer_req),
        .xfer_ready (xfer_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    initial tclock = 1'b0;
    always #5 tclock = ~tclock;

    function automatic logic [DW-1:0] word_for(input int tag, input int idx);
        if (tag == 0 && idx == 0) return 32'hDEADBEEF;
        return 32'hA500_0000 | DW'(tag * 256 + idx * 16 + 5);
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every word the transmitter takes must match the oldest predicted grant.
    always @(negedge tclock) begin : monitor
        exp_t e;
        if (reset === 1'b1 && xfer_req === 1'b1 && xfer_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_underflow: got word %h expected none at %0t", xfer_data, $time);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_word", {grant_id, xfer_data}, {e.id, e.data});
            end
            exp_count = exp_count + 16'd1;
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns #1 after the offer edge.
    task automatic apply_stimulus(input logic [NR-1:0] valid, input int exp_g, input int tag, input logic rdy);
        logic [NR-1:0] onehot;
        logic [DW-1:0] word;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_for(tag, i);
        onehot        = '0;
        onehot[exp_g] = 1'b1;
        word          = word_for(tag, exp_g);
        req_valid     = valid;
        xfer_ready    = rdy;
        sb_q.push_back('{id: IW'(exp_g), data: word});
        @(negedge tclock);
        check_output($sformatf("req_ready_t%0d", tag), {busy, req_ready}, {1'b0, onehot});
        check_output($sformatf("count_idle_t%0d", tag), xfer_count, exp_count);
        @(posedge tclock);
        #1;
        req_valid = '0;
        @(negedge tclock);
        check_output($sformatf("offer_t%0d", tag), {xfer_req, busy, req_ready, grant_id, xfer_data},
                     {1'b1, 1'b1, 4'b0000, IW'(exp_g), word});
        @(posedge tclock);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'b0001, 0};
        vecs[1] = '{4'b0001, 0};
        vecs[2] = '{4'b0110, 1};
        vecs[3] = '{4'b0110, FIXED ? 1 : 2};
        vecs[4] = '{4'b0100, 2};
        vecs[5] = '{4'b0101, 0};
        vecs[6] = '{4'b1100, 2};
        vecs[7] = '{4'b1100, FIXED ? 2 : 3};
        vecs[8] = '{4'b1010, 1};
        vecs[9] = '{4'b1000, 3};
        order   = FIXED ? '{0, 0, 0, 0, 0} : '{0, 1, 2, 3, 0};

        reset      = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        xfer_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_output("rst_xfer_req", xfer_req, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_grant_id", grant_id, 0);
        check_output("rst_xfer_data", xfer_data, 0);
        check_output("rst_count", xfer_count, 0);
        check_output("rst_req_ready", req_ready, 0);
        @(posedge tclock);
        @(posedge tclock);
        #1 reset = 1'b1;

        $display("[TB] grant vector table");
        for (int k = 0; k < 10; k++) apply_stimulus(vecs[k].valid, vecs[k].grant, k, 1'b1);

        $display("[TB] all requesters held valid");
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_for(20, i);
        req_valid  = 4'b1111;
        xfer_ready = 1'b1;
        for (int k = 0; k < 5; k++) sb_q.push_back('{id: IW'(order[k]), data: word_for(20, order[k])});
        for (int c = 0; c < 10; c++) begin
            logic [NR-1:0] exp_rr;
            @(negedge tclock);
            exp_rr = '0;
            if (c % 2 == 0) exp_rr[order[c/2]] = 1'b1;
            check_output($sformatf("rr_cycle%0d", c), req_ready, exp_rr);
        end
        @(posedge tclock);
        #1;
        req_valid  = '0;
        xfer_ready = 1'b0;

        $display("[TB] transmitter stall");
        apply_stimulus(4'b0010, 1, 30, 1'b0);
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_for(31, i);
        req_valid = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            @(negedge tclock);
            check_output($sformatf("stall%0d", c), {xfer_req, busy, req_ready, grant_id, xfer_data},
                         {1'b1, 1'b1, 4'b0000, 2'd1, word_for(30, 1)});
        end
        @(posedge tclock);
        #1 xfer_ready = 1'b1;
        @(posedge tclock);
        #1;
        apply_stimulus(4'b1101, FIXED ? 0 : 2, 31, 1'b1);

        $display("[TB] counter wrap");
        #1 force dut.xfer_count_q = 16'hFFFF;
        #1 release dut.xfer_count_q;
        exp_count = 16'hFFFF;
        apply_stimulus(4'b0001, 0, 40, 1'b1);
        @(negedge tclock);
        check_output("count_wrap", xfer_count, 16'h0000);
        @(posedge tclock);
        #1;

        $display("[TB] reset during offer");
        apply_stimulus(4'b0100, 2, 50, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_output("midrst_outputs", {xfer_req, busy, grant_id, xfer_data, xfer_count},
                     {1'b0, 1'b0, 2'd0, 32'h0, 16'h0});
        sb_q.delete();
        exp_count = '0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_for(51, i);
        req_valid  = 4'b1001;
        xfer_ready = 1'b1;
        @(negedge tclock);
        check_output("midrst_req_ready", {xfer_req, req_ready}, 5'b0);
        @(posedge tclock);
        #1 reset = 1'b1;
        apply_stimulus(4'b1001, 0, 51, 1'b1);
        @(negedge tclock);
        check_output("post_rst_count", xfer_count, 16'd1);
        check_output("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
